// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM state encoding and default coefficient width for the FIR tap loader
package fir_pkg;
  localparam int TW_DEFAULT = 16;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RD_CAP  = 3'd2,
    RD_PRES = 3'd3,
    RD_WAIT = 3'd4
  } state_t;
endpackage

// File: rtl/fir_tap_loader_if.sv
// fir_tap_loader_if: coefficient load stream (host -> loader) and readback stream (loader -> host)
interface fir_tap_loader_if #(parameter int TW = fir_pkg::TW_DEFAULT);
  logic          coef_valid;
  logic          coef_ready;
  logic [TW-1:0] coef;
  logic          rd_valid;
  logic          rd_ready;
  logic [TW-1:0] rd_data;
  modport master(output coef_valid, coef, rd_ready, input coef_ready, rd_valid, rd_data);
  modport slave(input coef_valid, coef, rd_ready, output coef_ready, rd_valid, rd_data);
endinterface

// File: rtl/fir_tap_loader.sv
// fir_tap_loader: shifts NTAPS coefficients into a daisy-chained FIR tap chain; readback by rotation when FIR_TAP_READBACK_EN is defined
module fir_tap_loader
  import fir_pkg::*;
#(
  parameter int TW    = TW_DEFAULT,
  parameter int NTAPS = 128
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  fir_tap_loader_if.slave bus,
  output logic          o_tap_wr,
  output logic [TW-1:0] o_tap,
  input  logic [TW-1:0] i_tail_tap,
  output logic          o_busy,
  output logic          o_loaded,
  input  logic          i_readback
);
  localparam int CW = $clog2(NTAPS + 1);
  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [TW-1:0] tap_n;
  logic          tap_wr_n, loaded_n, last;
  assign last            = count == CW'(NTAPS - 1);
  assign o_busy          = state != IDLE;
  assign bus.coef_ready  = state == LOAD;
`ifdef FIR_TAP_READBACK_EN
  logic [TW-1:0] rd_data, rd_data_n;
  assign bus.rd_valid = state == RD_PRES;
  assign bus.rd_data  = rd_data;
`else
  wire unused = &{1'b0, i_readback, bus.rd_ready, i_tail_tap};
  assign bus.rd_valid = 1'b0;
  assign bus.rd_data  = '0;
`endif
  // next-state and next-output decode; the write strobe only lives for the cycle after a handshake
  always_comb begin
    state_n  = state;
    count_n  = count;
    tap_n    = o_tap;
    tap_wr_n = 1'b0;
    loaded_n = o_loaded;
`ifdef FIR_TAP_READBACK_EN
    rd_data_n = rd_data;
`endif
    case (state)
      IDLE: begin
        if (i_start) begin
          state_n  = LOAD;
          count_n  = '0;
          loaded_n = 1'b0;
        end
`ifdef FIR_TAP_READBACK_EN
        else if (i_readback && o_loaded) begin
          state_n = RD_CAP;
          count_n = '0;
        end
`endif
      end
      LOAD: begin
        if (i_start) count_n = '0;
        else if (bus.coef_valid) begin
          tap_n    = bus.coef;
          tap_wr_n = 1'b1;
          count_n  = count + 1'b1;
          state_n  = last ? IDLE : LOAD;
          loaded_n = last;
        end
      end
`ifdef FIR_TAP_READBACK_EN
      RD_CAP: begin
        rd_data_n = i_tail_tap;
        state_n   = RD_PRES;
      end
      RD_PRES: begin
        if (bus.rd_ready) begin
          tap_n    = rd_data;
          tap_wr_n = 1'b1;
          count_n  = count + 1'b1;
          state_n  = last ? IDLE : RD_WAIT;
        end
      end
      RD_WAIT: state_n = RD_CAP;
`endif
      default: state_n = IDLE;
    endcase
  end
  // state, counter and registered outputs; reset aborts any load or readback and invalidates the chain
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      count    <= '0;
      o_tap_wr <= 1'b0;
      o_tap    <= '0;
      o_loaded <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      o_tap_wr <= tap_wr_n;
      o_tap    <= tap_n;
      o_loaded <= loaded_n;
    end
  end
`ifdef FIR_TAP_READBACK_EN
  // captured tail value presented on the readback stream
  always_ff @(posedge i_clk) begin
    if (i_reset) rd_data <= '0;
    else rd_data <= rd_data_n;
  end
`endif
endmodule

// File: tb/tb_fir_tap_loader.sv
// tb_fir_tap_loader: randomized and directed bench with a transaction-level model of the loader and its tap chain
module tb_fir_tap_loader;
  localparam int TW = 16;
  localparam int N  = 4;
`ifdef FIR_TAP_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, readback = 1'b0;
  logic tap_wr, busy, loaded;
  logic [TW-1:0] tap, tail;
  int n_chk = 0, n_fail = 0;
  fir_tap_loader_if #(.TW(TW)) bus ();
  fir_tap_loader #(.TW(TW), .NTAPS(N)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .bus(bus),
    .o_tap_wr(tap_wr), .o_tap(tap), .i_tail_tap(tail),
    .o_busy(busy), .o_loaded(loaded), .i_readback(readback)
  );
  always #5 clk = ~clk;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // stand-in for the external tap chain, driven by the DUT; position 0 is the head
  logic [TW-1:0] chain [N];
  int  wr_cnt = 0;
  bit  bad_seen = 0;
  initial for (int i = 0; i < N; i++) chain[i] = '0;
  assign tail = chain[N-1];
  always @(posedge clk) if (tap_wr) begin
    for (int i = N - 1; i > 0; i--) chain[i] <= chain[i-1];
    chain[0] <= tap;
    wr_cnt   <= wr_cnt + 1;
    if (tap == 16'hDEAD) bad_seen <= 1'b1;
  end

  // reference model: mode 0 idle, 1 loading, 2 readback (ph: 0 capture, 1 present, 2 settle)
  int mode = 0, cnt = 0, ph = 0;
  bit m_wr = 0, m_loaded = 0, chk = 0;
  logic [TW-1:0] m_tap = '0, m_rdd = '0, t;
  logic [TW-1:0] mch [N];
  initial for (int i = 0; i < N; i++) mch[i] = '0;
  always @(posedge clk) begin
    t = mch[N-1];
    if (m_wr) begin
      for (int i = N - 1; i > 0; i--) mch[i] = mch[i-1];
      mch[0] = m_tap;
    end
    m_wr = 0;
    if (rst) begin
      mode = 0; cnt = 0; m_tap = '0; m_loaded = 0; m_rdd = '0;
    end else if (mode == 0) begin
      if (start) begin mode = 1; cnt = 0; m_loaded = 0; end
      else if (RB && readback && m_loaded) begin mode = 2; cnt = 0; ph = 0; end
    end else if (mode == 1) begin
      if (start) cnt = 0;
      else if (bus.coef_valid) begin
        m_wr = 1; m_tap = bus.coef; cnt++;
        if (cnt == N) begin mode = 0; m_loaded = 1; end
      end
    end else if (ph == 0) begin
      m_rdd = t; ph = 1;
    end else if (ph == 1) begin
      if (bus.rd_ready) begin
        m_wr = 1; m_tap = m_rdd; cnt++;
        if (cnt == N) mode = 0; else ph = 2;
      end
    end else ph = 0;
    chk = 1;
  end

  // per-cycle comparison against the model, plus a log of readback handshakes
  logic [TW-1:0] rdq [$];
  always @(negedge clk) if (chk) begin
    cmp("coef_ready", bus.coef_ready, mode == 1);
    cmp("busy", busy, mode != 0);
    cmp("tap_wr", tap_wr, m_wr);
    cmp("tap", tap, m_tap);
    cmp("loaded", loaded, m_loaded);
    cmp("rd_valid", bus.rd_valid, mode == 2 && ph == 1);
    cmp("rd_data", bus.rd_data, m_rdd);
    if (bus.rd_valid && bus.rd_ready) rdq.push_back(bus.rd_data);
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(logic [TW-1:0] base, bit toggle);
    int k = 0;
    bit v = 1;
    start = 1; tick(); start = 0;
    while (k < N) begin
      bus.coef_valid = v; bus.coef = base + TW'(k);
      tick();
      if (v) k++;
      if (toggle) v = !v;
    end
    bus.coef_valid = 0;
    tick(3);
  endtask

  task automatic check_chain(string nm, logic [TW-1:0] base);
    for (int k = 0; k < N; k++) cmp(nm, chain[N-1-k], base + TW'(k));
  endtask

  initial begin
    int w;
    int q0;
    bus.coef_valid = 0; bus.coef = '0; bus.rd_ready = 1;
    tick(2); rst = 0; tick();
    cmp("reset_loaded", loaded, 0);
    cmp("reset_tap", tap, 0);
    w = wr_cnt;
    load(16'h0001, 0);
    check_chain("b2b_chain", 16'h0001);
    cmp("b2b_loaded", loaded, 1);
    cmp("b2b_writes", wr_cnt - w, N);
    w = wr_cnt;
    load(16'h0101, 1);
    check_chain("toggle_chain", 16'h0101);
    cmp("toggle_writes", wr_cnt - w, N);
    start = 1; tick(); start = 0;
    bus.coef_valid = 1; bus.coef = 16'h0055; tick();
    bus.coef = 16'h0056; tick();
    bus.coef_valid = 0; rst = 1; tick(); rst = 0;
    cmp("rst_tap_wr", tap_wr, 0);
    cmp("rst_tap", tap, 0);
    cmp("rst_loaded", loaded, 0);
    cmp("rst_busy", busy, 0);
    w = wr_cnt; tick(3);
    cmp("rst_no_writes", wr_cnt - w, 0);
    load(16'h0010, 0);
    check_chain("after_rst_chain", 16'h0010);
    start = 1; tick(); start = 0;
    for (int k = 0; k < 3; k++) begin bus.coef_valid = 1; bus.coef = 16'h0030 + TW'(k); tick(); end
    start = 1; bus.coef = 16'hDEAD; tick(); start = 0;
    for (int k = 0; k < N; k++) begin bus.coef = 16'h0021 + TW'(k); tick(); end
    bus.coef_valid = 0; tick(3);
    check_chain("restart_chain", 16'h0021);
    cmp("restart_discard", bad_seen, 0);
    cmp("restart_loaded", loaded, 1);
    w = wr_cnt; q0 = rdq.size();
    bus.rd_ready = 1; readback = 1; tick(); readback = 0;
    tick(3 * N + 4);
    cmp("rb_count", rdq.size() - q0, RB ? N : 0);
    if (rdq.size() - q0 == N) for (int k = 0; k < N; k++) cmp("rb_data", rdq[q0+k], 16'h0021 + TW'(k));
    check_chain("rb_chain_kept", 16'h0021);
    cmp("rb_loaded", loaded, 1);
    cmp("rb_writes", wr_cnt - w, RB ? N : 0);
    readback = 1; tick(); readback = 0;
    repeat (40) begin bus.rd_ready = 1'($urandom); tick(); end
    bus.rd_ready = 1; tick(20);
    check_chain("rb_stall_chain", 16'h0021);
    rst = 1; tick(); rst = 0;
    w = wr_cnt; q0 = rdq.size();
    readback = 1; tick(); readback = 0;
    cmp("rb_unloaded_busy", busy, 0);
    tick(8);
    cmp("rb_unloaded_writes", wr_cnt - w, 0);
    cmp("rb_unloaded_rd", rdq.size() - q0, 0);
    repeat (3000) begin
      rst = ($urandom % 200) == 0;
      start = ($urandom % 40) == 0;
      readback = ($urandom % 30) == 0;
      bus.coef_valid = ($urandom % 4) != 0;
      bus.coef = TW'($urandom);
      bus.rd_ready = 1'($urandom);
      tick();
    end
    rst = 0; start = 0; readback = 0; bus.coef_valid = 0;
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_tap_loader.md
Name: fir_tap_loader

Overview:
- Writer side of the daisy-chained adjustable-tap FIR tap shift chain (tap modules built with FIXED_TAPS=0).
- Accepts NTAPS coefficients over a valid/ready stream and shifts each into the chain head using a write strobe plus tap value.
- Reports load completion to the host.
- Optional feature: nondestructive readback. The chain is rotated through its tail tap, and each coefficient is presented on an output stream.

Parameters:
- TW, 16, coefficient width in bits.
- NTAPS, 128, number of taps in the chain; must be at least 2.
- CW, $clog2(NTAPS+1), localparam, width of the tap counter.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset (see Behaviour)
- i_start  in  1  pulse: begin a new load of NTAPS coefficients
- i_coef_valid  in  1  coefficient stream valid
- i_coef  in  TW  coefficient value
- o_coef_ready  out  1  coefficient stream ready
- o_tap_wr  out  1  shift strobe to the chain
- o_tap  out  TW  value shifted into the chain head
- i_tail_tap  in  TW  o_tap output of the last tap in the chain
- o_busy  out  1  high whenever state is not IDLE
- o_loaded  out  1  chain holds a complete, valid coefficient set
- i_readback  in  1  pulse: begin readback
- o_rd_valid  out  1  readback stream valid
- o_rd_data  out  TW  readback coefficient
- i_rd_ready  in  1  readback stream ready

Behaviour:
- Reset: reset i_reset, synchronous, active-high; clock i_clk.
  - Reset returns state to IDLE and clears count, o_tap_wr, o_tap, o_loaded, o_rd_valid and o_rd_data to 0.
  - Reset mid-load or mid-readback aborts immediately. The chain contents become undefined, which is why o_loaded=0.
- States: IDLE, LOAD, RD_CAP, RD_PRES, RD_WAIT.
- o_coef_ready is 1 only in LOAD.
- o_rd_valid is 1 only in RD_PRES.
- IDLE:
  - i_start goes to LOAD, with count=0 and o_loaded=0.
  - i_readback with o_loaded=1 goes to RD_CAP, with count=0.
  - i_readback with o_loaded=0 is ignored.
  - If i_start and i_readback arrive together, i_start wins.
- LOAD: on each accept (i_coef_valid & o_coef_ready):
  - Next cycle: o_tap=i_coef and o_tap_wr=1. One-cycle latency, so the chain shifts one cycle after accept.
  - count increments on each accept.
  - On the NTAPS-th accept: next state IDLE and o_loaded=1 in the same cycle as the last o_tap_wr.
  - Full throughput is one coefficient per clock.
  - o_tap_wr is 0 on every cycle without an accept. o_tap holds its last value.
- Ordering: the k-th accepted coefficient (0-based) ends at chain position NTAPS-1-k. The host therefore sends the tail tap first.
- i_start during LOAD restarts the load: count=0. A coefficient accepted in that same cycle is discarded and not written.
- Tap shifting happens only on o_tap_wr. The filter sample path is unaffected.
  - Output during LOAD is a mix of old and new taps.
  - The parent uses o_busy to gate or flag output.
- Readback states:
  - RD_CAP: o_rd_data <= i_tail_tap, then go to RD_PRES.
  - RD_PRES: o_rd_valid=1. On i_rd_ready: o_tap <= o_rd_data, o_tap_wr <= 1, count++. Then go to RD_WAIT, or to IDLE if count reaches NTAPS.
  - RD_WAIT: the chain shifts this cycle. Then go to RD_CAP, where the new tail is stable.
  - Throughput is one tap per 3 cycles minimum.
  - After NTAPS rotations the chain is restored, and o_loaded stays 1.
  - Readback order is the same tail-first order as load.
- i_start during readback is ignored until IDLE.
- o_tap_wr is never asserted in IDLE except on the cycle right after the final accept or final readback handshake.

Optional Feature:
- Macro FIR_TAP_READBACK_EN.
- Defined: the RD_* states and readback ports behave as above.
- Undefined:
  - The RD_* states are not built.
  - i_readback, i_rd_ready and i_tail_tap are ignored and collected into an unused wire.
  - o_rd_valid=0 and o_rd_data=0 constant.
  - The LOAD path is identical in both builds.

Decomposition:
- Shared package fir_pkg holds:
  - the state encoding constants (3-bit: IDLE=0, LOAD=1, RD_CAP=2, RD_PRES=3, RD_WAIT=4);
  - the default coefficient width constant (16).
- No sub-module. The counter, FSM and output registers live in one module.

Test Plan:
- NTAPS=4, TW=16, i_start, then stream 0x0001, 0x0002, 0x0003, 0x0004 back-to-back:
  - o_tap_wr high for 4 consecutive cycles, each one cycle after its accept;
  - chain positions 3..0 hold 1, 2, 3, 4;
  - o_loaded=1 on the last write cycle; o_busy=0 the cycle after.
- Same load with i_coef_valid toggling 1,0,1,0:
  - o_tap_wr pulses only after accepts;
  - 4 writes total; o_tap holds between writes.
- i_reset after the 2nd accept:
  - outputs 0 next cycle; o_loaded=0; no further o_tap_wr;
  - a new i_start loads 4 coefficients normally.
- i_start re-asserted after the 3rd accept, with i_coef_valid high on that cycle:
  - that coefficient is not written;
  - exactly 4 further accepts are needed before o_loaded=1.
- FIR_TAP_READBACK_EN defined, after load, i_readback with i_rd_ready=1:
  - o_rd_data sequence 0x0001..0x0004, one per 3 cycles;
  - chain contents unchanged afterward; o_loaded stays 1.
- i_readback with o_loaded=0, or with the macro undefined:
  - no state change, o_rd_valid stays 0, no o_tap_wr.
